// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, FSM state encoding, iteration count
// and small decode/ALU helpers used by op_executor and calculator.
// Build option: OP_EXECUTOR_DIV_EN enables opcode 0x06 (DIV).
package calc_pkg;

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_AND = 8'h02;
   localparam logic [7:0] OP_OR  = 8'h03;
   localparam logic [7:0] OP_XOR = 8'h04;
   localparam logic [7:0] OP_MUL = 8'h05;
   localparam logic [7:0] OP_DIV = 8'h06;

   // MUL and DIV retire one result bit per cycle.
   localparam int ITER_N = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_A,
      ST_GET_B,
      ST_EXEC,
      ST_DONE
   } state_t;

   // Opcodes this build can execute; anything else is rejected in IDLE.
   function automatic logic op_known(input logic [7:0] op);
`ifdef OP_EXECUTOR_DIV_EN
      return (op <= OP_DIV);
`else
      return (op <= OP_MUL);
`endif
   endfunction

   // Single-cycle operations, all unsigned and wrapping at 8 bits.
   function automatic logic [7:0] alu_simple(input logic [7:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
      logic [7:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/op_seq_muldiv.sv
// Bit-serial MUL/DIV engine: MSB-first shift-add multiplier and restoring
// divider that share one 8-bit adder and one 3-bit iteration counter.
// start_i loads the operands; done_o is high during the last iteration with
// result_o carrying the finished value for the caller to register.
// Build option: OP_EXECUTOR_DIV_EN adds the divider path.
module op_seq_muldiv
   import calc_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       div_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic       done_o,
   output logic [7:0] result_o
);

   logic       busy_q;
   logic [2:0] cnt_q;
   // x: product accumulator / partial remainder
   // y: multiplier bits (shifted out MSB first) / dividend in, quotient out
   // m: multiplicand / divisor
   logic [7:0] x_q, y_q, m_q;
   logic [7:0] x_d, y_d;
   logic [7:0] add_x, add_y;
   logic       add_cin;
   logic [8:0] sum;

`ifdef OP_EXECUTOR_DIV_EN
   logic is_div_q;
   logic quo_bit;

   // Select adder operands: accumulate for MUL, trial-subtract for DIV.
   always_comb begin
      if (is_div_q) begin
         add_x   = {x_q[6:0], y_q[7]};
         add_y   = ~m_q;
         add_cin = 1'b1;
      end else begin
         add_x   = {x_q[6:0], 1'b0};
         add_y   = y_q[7] ? m_q : 8'h00;
         add_cin = 1'b0;
      end
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};

   // Next iteration state; remainder bit 7 set means the shifted value is >= 256.
   always_comb begin
      quo_bit = 1'b0;
      if (is_div_q) begin
         quo_bit = x_q[7] | sum[8];
         x_d     = quo_bit ? sum[7:0] : add_x;
         y_d     = {y_q[6:0], quo_bit};
      end else begin
         x_d     = sum[7:0];
         y_d     = {y_q[6:0], 1'b0};
      end
   end

   assign result_o = is_div_q ? y_d : x_d;
`else
   logic unused_nodiv;

   // Multiplier-only operand selection.
   always_comb begin
      add_x   = {x_q[6:0], 1'b0};
      add_y   = y_q[7] ? m_q : 8'h00;
      add_cin = 1'b0;
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};

   // Multiplier-only next iteration state.
   always_comb begin
      x_d = sum[7:0];
      y_d = {y_q[6:0], 1'b0};
   end

   assign result_o     = x_d;
   assign unused_nodiv = ^{div_i, sum[8]};
`endif

   assign done_o = busy_q && (cnt_q == 3'(ITER_N - 1));

   // Iteration control: run ITER_N cycles after start, abandoned on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= 3'd0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= 3'd0;
      end else if (busy_q) begin
         cnt_q <= cnt_q + 3'd1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

   // Operand load and per-iteration datapath update.
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         x_q <= 8'h00;
`ifdef OP_EXECUTOR_DIV_EN
         is_div_q <= div_i;
         if (div_i) begin
            y_q <= a_i;
            m_q <= b_i;
         end else begin
            y_q <= b_i;
            m_q <= a_i;
         end
`else
         y_q <= b_i;
         m_q <= a_i;
`endif
      end else if (busy_q) begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/op_executor.sv
// Byte-serial operation executor: collects opcode, operand A and operand B
// from a strobed byte stream, executes, and pulses result_valid for one cycle.
// Build option: OP_EXECUTOR_DIV_EN enables DIV (0x06); otherwise 0x06 is
// rejected as an unknown opcode and no divider is built.
module op_executor
   import calc_pkg::*;
(
   input  logic       clk_100MHz,
   input  logic       rst_n,
   input  logic       operation_enable,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       result_valid,
   output logic       busy,
   output logic       error
);

   state_t     state_q;
   logic       armed_q;
   logic [7:0] data_out_q;
   logic       result_valid_q;
   logic       busy_q;
   logic       error_q;
   logic [7:0] op_q, a_q, b_q;

   logic       capture;
   logic       op_is_mul;
   logic       op_is_div;
   logic       op_iter;
   logic       div_by_zero;
   logic       md_start;
   logic       md_done;
   logic [7:0] md_result;

   // armed_q keeps the first edge after reset release from capturing.
   assign capture = operation_enable && armed_q &&
                    (state_q inside {ST_IDLE, ST_GET_A, ST_GET_B});

   assign op_is_mul = (op_q == OP_MUL);
`ifdef OP_EXECUTOR_DIV_EN
   assign op_is_div = (op_q == OP_DIV);
`else
   assign op_is_div = 1'b0;
`endif
   assign op_iter     = op_is_mul || op_is_div;
   assign div_by_zero = op_is_div && (data_in == 8'h00);
   assign md_start    = capture && (state_q == ST_GET_B) && op_iter && !div_by_zero;

   op_seq_muldiv u_muldiv (
      .clk_i    (clk_100MHz),
      .rst_ni   (rst_n),
      .start_i  (md_start),
      .div_i    (op_is_div),
      .a_i      (a_q),
      .b_i      (data_in),
      .done_o   (md_done),
      .result_o (md_result)
   );

   // Request sequencing FSM with registered result/status outputs.
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         armed_q        <= 1'b0;
         data_out_q     <= 8'h00;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         armed_q        <= 1'b1;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (capture) begin
                  if (op_known(data_in)) begin
                     state_q <= ST_GET_A;
                  end else begin
                     state_q        <= ST_DONE;
                     data_out_q     <= 8'h00;
                     result_valid_q <= 1'b1;
                     error_q        <= 1'b1;
                     busy_q         <= 1'b1;
                  end
               end
            end
            ST_GET_A: begin
               if (capture) begin
                  state_q <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (capture) begin
                  busy_q <= 1'b1;
                  if (div_by_zero) begin
                     state_q        <= ST_DONE;
                     data_out_q     <= 8'hFF;
                     result_valid_q <= 1'b1;
                     error_q        <= 1'b1;
                  end else begin
                     state_q <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (!op_iter) begin
                  state_q        <= ST_DONE;
                  data_out_q     <= alu_simple(op_q, a_q, b_q);
                  result_valid_q <= 1'b1;
               end else if (md_done) begin
                  state_q        <= ST_DONE;
                  data_out_q     <= md_result;
                  result_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Capture opcode and operand bytes as they are accepted.
   always_ff @(posedge clk_100MHz) begin
      if (capture) begin
         case (state_q)
            ST_IDLE:  op_q <= data_in;
            ST_GET_A: a_q  <= data_in;
            ST_GET_B: b_q  <= data_in;
            default:  ;
         endcase
      end
   end

   assign data_out     = data_out_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;
   assign error        = error_q;

endmodule

// File: tb/tb_op_executor.sv
// Randomized scoreboard bench for op_executor with directed request scenarios.
module tb_op_executor;

   logic       clk_100MHz = 1'b0;
   logic       rst_n;
   logic       operation_enable;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       result_valid;
   logic       busy;
   logic       error;

`ifdef OP_EXECUTOR_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   op_executor dut (
      .clk_100MHz       (clk_100MHz),
      .rst_n            (rst_n),
      .operation_enable (operation_enable),
      .data_in          (data_in),
      .data_out         (data_out),
      .result_valid     (result_valid),
      .busy             (busy),
      .error            (error)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int unsigned cyc = 0;
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  data;
      logic        err;
      int unsigned edge_n;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: result, error flag and edges from final byte capture to sampled pulse.
   function automatic bit model_known(input logic [7:0] op);
      return (op <= 8'd5) || (DIV_EN && op == 8'd6);
   endfunction

   function automatic void model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic e, output int lat);
      int ai, bi;
      ai = int'(a);
      bi = int'(b);
      r = 8'h00; e = 1'b0; lat = 2;
      if (!model_known(op)) begin
         r = 8'h00; e = 1'b1; lat = 1;
      end else begin
         case (op)
            8'd0: r = 8'((ai + bi) % 256);
            8'd1: r = 8'((ai - bi + 256) % 256);
            8'd2: r = a & b;
            8'd3: r = a | b;
            8'd4: r = a ^ b;
            8'd5: begin r = 8'((ai * bi) % 256); lat = 9; end
            default: begin
               if (bi == 0) begin r = 8'hFF; e = 1'b1; lat = 1; end
               else begin r = 8'(ai / bi); lat = 9; end
            end
         endcase
      end
   endfunction

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk_100MHz) begin
      if (rst_n) begin
         check("error_only_with_valid", 32'(error & ~result_valid), 32'd0);
         if (result_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got data=0x%0h err=%0b, expected no result (cycle %0d)",
                        data_out, error, cyc);
            end else begin
               mon_e = sb.pop_front();
               check("data_out", 32'(data_out), 32'(mon_e.data));
               check("error", 32'(error), 32'(mon_e.err));
               check("result_edge", cyc + 1, mon_e.edge_n);
            end
         end
      end
   end

   // Offer one byte after an idle gap; returns the index of the capturing edge.
   task automatic strobe(input logic [7:0] d, input int gap, output int unsigned cap);
      for (int i = 0; i < gap; i++) begin
         @(posedge clk_100MHz); #1;
      end
      operation_enable = 1'b1;
      data_in          = d;
      @(posedge clk_100MHz); #1;
      cap              = cyc;
      operation_enable = 1'b0;
      data_in          = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 30) begin
         @(posedge clk_100MHz); #1;
         n++;
      end
      check("request_drained", 32'((sb.size() == 0) && !busy), 32'd1);
   endtask

   task automatic do_req(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit rnd_gap, input bit junk);
      int unsigned cap;
      logic [7:0]  r;
      logic        e;
      int          lat;
      model(op, a, b, r, e, lat);
      strobe(op, rnd_gap ? $urandom_range(0, 2) : 0, cap);
      if (model_known(op)) begin
         strobe(a, rnd_gap ? $urandom_range(0, 2) : 0, cap);
         strobe(b, rnd_gap ? $urandom_range(0, 2) : 0, cap);
      end
      sb.push_back('{data: r, err: e, edge_n: cap + 32'(lat)});
      if (junk) begin
         for (int i = 0; i < 20 && busy; i++) begin
            operation_enable = 1'($urandom);
            data_in          = 8'($urandom);
            @(posedge clk_100MHz); #1;
         end
         operation_enable = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      int unsigned cap;
      logic [7:0]  op, a, b;

      rst_n            = 1'b0;
      operation_enable = 1'b0;
      data_in          = 8'h00;
      repeat (3) @(posedge clk_100MHz);
      #1;
      check("reset_data_out", 32'(data_out), 32'h00);
      check("reset_valid", 32'(result_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_error", 32'(error), 32'd0);
      rst_n = 1'b1;
      @(posedge clk_100MHz); #1;

      // ADD wrap: 0xF0 + 0x20
      do_req(8'h00, 8'hF0, 8'h20, 1'b0, 1'b0);

      // MUL with busy held through EXEC and a stray strobe
      strobe(8'h05, 0, cap);
      strobe(8'h0D, 0, cap);
      strobe(8'h0B, 0, cap);
      sb.push_back('{data: 8'h8F, err: 1'b0, edge_n: cap + 9});
      for (int i = 0; i < 8; i++) begin
         check("busy_in_exec", 32'(busy), 32'd1);
         operation_enable = 1'b1;
         data_in          = 8'h01;
         @(posedge clk_100MHz); #1;
      end
      operation_enable = 1'b0;
      wait_idle();

      // DIV, including divide by zero (0x06 is unknown when DIV is not built)
      do_req(8'h06, 8'h64, 8'h07, 1'b0, 1'b0);
      do_req(8'h06, 8'h64, 8'h00, 1'b0, 1'b0);

      // Unknown opcode, then AND back-to-back
      do_req(8'h09, 8'h00, 8'h00, 1'b0, 1'b0);
      do_req(8'h02, 8'hF0, 8'h3C, 1'b0, 1'b0);

      // Reset mid-MUL: no pulse, outputs cleared, first edge after release ignored
      strobe(8'h05, 0, cap);
      strobe(8'h33, 0, cap);
      strobe(8'h44, 0, cap);
      repeat (3) begin
         @(posedge clk_100MHz); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midreset_data_out", 32'(data_out), 32'h00);
      check("midreset_valid", 32'(result_valid), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_error", 32'(error), 32'd0);
      repeat (12) begin
         @(posedge clk_100MHz); #1;
      end
      check("held_reset_data_out", 32'(data_out), 32'h00);
      rst_n            = 1'b1;
      operation_enable = 1'b1;
      data_in          = 8'h09;
      @(posedge clk_100MHz); #1;
      operation_enable = 1'b0;
      @(posedge clk_100MHz); #1;
      check("post_reset_idle", 32'(busy), 32'd0);
      do_req(8'h05, 8'h0D, 8'h0B, 1'b0, 1'b0);

      // Randomized requests with gaps and stray strobes while busy
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0:       op = 8'd5;
            1:       op = 8'd6;
            default: op = 8'($urandom_range(0, 9));
         endcase
         a = 8'($urandom);
         b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         do_req(op, a, b, 1'b1, 1'($urandom));
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
